// File: rtl/memcopy_dma.sv
// Single-command word-copy DMA that owns the data-memory port while busy.
// Optional overlap-safe (memmove) ordering is enabled with `define MEMCOPY_BACKWARD_EN.
module memcopy_dma #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [31:0]           src,
  input  logic [31:0]           dst,
  input  logic [31:0]           len,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [DATA_W-1:0]     mem_wd,
  input  logic [DATA_W-1:0]     mem_rd
);

  // state   | meaning
  // S_IDLE  | waiting for start, port released
  // S_READ  | issuing read of word i
  // S_WRITE | writing word i with the read data passed through
  // S_DONE  | one-cycle completion pulse
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [DM_ADDRESS-1:0] PTR_ONE = {{(DM_ADDRESS-1){1'b0}}, 1'b1};

  logic [1:0]            state;
  logic [31:0]           len_q;
  logic [31:0]           idx;
  logic [DM_ADDRESS-1:0] rd_base;
  logic [DM_ADDRESS-1:0] wr_base;
  logic [DM_ADDRESS-1:0] rd_ptr;
  logic [DM_ADDRESS-1:0] wr_ptr;
  logic [DM_ADDRESS-1:0] idx_lo;
  logic [DM_ADDRESS-1:0] back_off;
  logic                  abort_flag;
  logic                  last_word;

  assign idx_lo    = idx[DM_ADDRESS-1:0];
  assign last_word = ((idx + 32'd1) == len_q);

`ifdef MEMCOPY_BACKWARD_EN
  logic backward;
  logic back_q;

  // Overlapping forward-shifted copies must run from the top down to avoid clobbering.
  assign backward = (dst > src) && ({1'b0, dst} < ({1'b0, src} + {1'b0, len}));
  assign back_off = backward ? (len[DM_ADDRESS-1:0] - PTR_ONE) : '0;
  assign rd_ptr   = back_q ? (rd_base - idx_lo) : (rd_base + idx_lo);
  assign wr_ptr   = back_q ? (wr_base - idx_lo) : (wr_base + idx_lo);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      back_q <= 1'b0;
    end else if (state == S_IDLE && start) begin
      back_q <= backward;
    end
  end
`else
  logic unused_addr_hi;

  assign unused_addr_hi = ^{src[31:DM_ADDRESS], dst[31:DM_ADDRESS], PTR_ONE};
  assign back_off       = '0;
  assign rd_ptr         = rd_base + idx_lo;
  assign wr_ptr         = wr_base + idx_lo;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      len_q      <= '0;
      idx        <= '0;
      rd_base    <= '0;
      wr_base    <= '0;
      abort_flag <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            len_q   <= len;
            idx     <= '0;
            rd_base <= src[DM_ADDRESS-1:0] + back_off;
            wr_base <= dst[DM_ADDRESS-1:0] + back_off;
            state   <= (len == 32'd0) ? S_DONE : S_READ;
          end
        end
        S_READ: begin
          if (abort) abort_flag <= 1'b1;
          state <= S_WRITE;
        end
        S_WRITE: begin
          idx <= idx + 32'd1;
          if (abort) abort_flag <= 1'b1;
          state <= (last_word || abort_flag || abort) ? S_DONE : S_READ;
        end
        S_DONE: begin
          abort_flag <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy     = (state == S_READ) || (state == S_WRITE);
    done     = (state == S_DONE);
    aborted  = (state == S_DONE) && abort_flag;
    mem_re   = (state == S_READ);
    mem_we   = (state == S_WRITE);
    mem_addr = '0;
    mem_wd   = '0;
    if (state == S_READ) begin
      mem_addr = rd_ptr;
    end else if (state == S_WRITE) begin
      mem_addr = wr_ptr;
      mem_wd   = mem_rd;
    end
  end

endmodule

// File: tb/tb_memcopy_dma.sv
// Scoreboard bench for memcopy_dma: a word-level copy model predicts every read,
// write and done event with its cycle; a negedge monitor checks what the DUT presents.
module tb_memcopy_dma;
  localparam int AW    = 9;
  localparam int DEPTH = 512;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] src = '0;
  logic [31:0] dst = '0;
  logic [31:0] len = '0;
  logic        busy, done, aborted, mem_re, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd = '0;

  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          cyc;
  } acc_t;

  typedef struct {
    int   cyc;
    logic ab;
  } done_t;

  acc_t  rd_q[$];
  acc_t  wr_q[$];
  done_t dn_q[$];
  acc_t  mon_e;
  done_t mon_d;

  memcopy_dma #(.DM_ADDRESS(AW), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src(src), .dst(dst), .len(len),
    .abort(abort), .busy(busy), .done(done), .aborted(aborted),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wd(mem_wd),
    .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wd;
    if (mem_re) mem_rd <= mem[mem_addr];
  end

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void unexpected(string nm);
    total++;
    bad++;
    $display("FAIL %s: got an event, want none (cycle %0d)", nm, cyc);
  endfunction

  // Word-at-a-time copy on the reference memory; overlap effects fall out naturally.
  function automatic void model_copy(logic [31:0] s, logic [31:0] d, int li, int n, int c0);
    logic        bk = 1'b0;
    logic [31:0] ta, tb;
    int          k2;
    acc_t        r, w;
`ifdef MEMCOPY_BACKWARD_EN
    bk = (d > s) && ({1'b0, d} < ({1'b0, s} + 33'(li)));
`endif
    for (int k = 0; k < n; k++) begin
      k2 = bk ? (li - 1 - k) : k;
      ta = s + 32'(k2);
      tb = d + 32'(k2);
      r.addr = int'(ta[AW-1:0]);
      r.data = '0;
      r.cyc  = c0 + 2 * k + 1;
      w.addr = int'(tb[AW-1:0]);
      w.data = ref_mem[r.addr];
      w.cyc  = c0 + 2 * k + 2;
      ref_mem[w.addr] = w.data;
      rd_q.push_back(r);
      wr_q.push_back(w);
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy_vs_access", busy, mem_re | mem_we);
      chk("re_we_excl", mem_re & mem_we, 0);
      if (mem_re) begin
        if (rd_q.size() == 0) unexpected("rd_unexpected");
        else begin
          mon_e = rd_q.pop_front();
          chk("rd_addr", mem_addr, mon_e.addr);
          chk("rd_cycle", cyc, mon_e.cyc);
        end
      end
      if (mem_we) begin
        if (wr_q.size() == 0) unexpected("wr_unexpected");
        else begin
          mon_e = wr_q.pop_front();
          chk("wr_addr", mem_addr, mon_e.addr);
          chk("wr_data", mem_wd, mon_e.data);
          chk("wr_cycle", cyc, mon_e.cyc);
        end
      end
      if (done) begin
        if (dn_q.size() == 0) unexpected("done_unexpected");
        else begin
          mon_d = dn_q.pop_front();
          chk("done_cycle", cyc, mon_d.cyc);
          chk("done_aborted", aborted, mon_d.ab);
        end
      end
    end
  end

  function automatic void drain_checks();
    chk("rd_drain", rd_q.size(), 0);
    chk("wr_drain", wr_q.size(), 0);
    chk("done_drain", dn_q.size(), 0);
    rd_q.delete();
    wr_q.delete();
    dn_q.delete();
  endfunction

  // Called #1 after a posedge; ab_t/st_t are cycle offsets (0 = none) for abort/stray start.
  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l,
                          input int ab_t, input int st_t);
    int    li, n, c0, st;
    logic  ab;
    done_t de;
    li = int'(l);
    if (ab_t >= 1 && ab_t <= 2 * li) begin
      n  = (ab_t - 1) / 2 + 1;
      ab = 1'b1;
    end else begin
      n  = li;
      ab = 1'b0;
    end
    st = (st_t > 2 * n + 1) ? 0 : st_t;
    c0 = cyc;
    model_copy(s, d, li, n, c0);
    de.cyc = c0 + 2 * n + 1;
    de.ab  = ab;
    dn_q.push_back(de);
    start = 1'b1;
    src = s;
    dst = d;
    len = l;
    @(posedge clk); #1;
    start = 1'b0;
    src = $urandom;
    dst = $urandom;
    len = $urandom;
    for (int off = 1; off <= 2 * n + 3; off++) begin
      abort = (off == ab_t);
      start = (off == st);
      if (off == st) begin
        src = $urandom_range(0, 511);
        dst = $urandom_range(0, 511);
        len = $urandom_range(1, 5);
      end
      @(posedge clk); #1;
    end
    abort = 1'b0;
    start = 1'b0;
    drain_checks();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] pat [4];
    logic [31:0] s, d, l;
    int          c0, ab_t, st_t;
    pat = '{32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003, 32'hD0D0_0004};
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {busy, done, aborted, mem_re, mem_we, mem_addr, mem_wd}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // basic ascending copy
    for (int k = 0; k < 4; k++) begin
      mem[10 + k]     = pat[k];
      ref_mem[10 + k] = pat[k];
    end
    run_copy(32'd10, 32'd100, 32'd4, 0, 0);
    for (int k = 0; k < 4; k++) chk("copy_basic_mem", mem[100 + k], pat[k]);

    // zero length
    run_copy(32'd77, 32'd200, 32'd0, 0, 0);

    // source wrap past top of memory
    run_copy(32'd510, 32'd20, 32'd4, 0, 0);

    // abort during third read, then abort with last write, then abort in DONE (ignored)
    run_copy(32'd30, 32'd250, 32'd8, 5, 0);
    run_copy(32'd60, 32'd400, 32'd3, 6, 0);
    run_copy(32'd61, 32'd410, 32'd3, 7, 0);

    // overlapping forward copy
    for (int k = 0; k < 6; k++) begin
      mem[k]     = 32'(k);
      ref_mem[k] = 32'(k);
    end
    run_copy(32'd0, 32'd2, 32'd4, 0, 0);
`ifdef MEMCOPY_BACKWARD_EN
    chk("overlap_m2", mem[2], 0);
    chk("overlap_m3", mem[3], 1);
    chk("overlap_m4", mem[4], 2);
    chk("overlap_m5", mem[5], 3);
`else
    chk("overlap_m2", mem[2], 0);
    chk("overlap_m3", mem[3], 1);
    chk("overlap_m4", mem[4], 0);
    chk("overlap_m5", mem[5], 1);
`endif

    // reset in the middle of a copy after two words are written
    c0 = cyc;
    model_copy(32'd40, 32'd300, 6, 2, c0);
    start = 1'b1;
    src = 32'd40;
    dst = 32'd300;
    len = 32'd6;
    @(posedge clk); #1;
    start = 1'b0;
    for (int off = 1; off <= 4; off++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("reset_mid_copy", {busy, done, aborted, mem_re, mem_we, mem_addr, mem_wd}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    drain_checks();
    chk("kept_write0", mem[300], ref_mem[300]);
    chk("kept_write1", mem[301], ref_mem[301]);

    // start pulses while busy and while in DONE are ignored
    run_copy(32'd5, 32'd350, 32'd3, 0, 3);
    run_copy(32'd8, 32'd360, 32'd3, 0, 7);

    for (int it = 0; it < 40; it++) begin
      s = $urandom_range(0, 1023);
      if ($urandom_range(0, 1) == 1) d = s + $urandom_range(0, 12) - 32'd6;
      else d = $urandom_range(0, 1023);
      l = $urandom_range(0, 10);
      ab_t = ($urandom_range(0, 9) < 3) ? $urandom_range(1, 2 * int'(l) + 1) : 0;
      st_t = ($urandom_range(0, 9) < 3) ? $urandom_range(1, 2 * int'(l) + 1) : 0;
      run_copy(s, d, l, ab_t, st_t);
    end

    for (int i = 0; i < DEPTH; i++) begin
      if (mem[i] !== ref_mem[i]) chk("final_mem", mem[i], ref_mem[i]);
    end
    chk("final_mem_sample", mem[100], pat[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
